// File: rtl/entry_access_controller.sv
// N-channel entry front end: synchronised, debounced request buttons feed per-channel
// pending flags; a round-robin arbiter selects one channel at a time for a timed display window.
module entry_access_controller #(
  parameter int NCH         = 2,
  parameter int CW          = 3,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8,
  localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    btn_n,
  input  logic [NCH*CW-1:0] sw_code,
  input  logic [NCH-1:0]    sw_en,
  output logic [NCH-1:0]    pend_led,
  output logic              busy,
  output logic              disp_valid,
  output logic [SELW-1:0]   disp_ch,
  output logic [CW-1:0]     disp_code,
  output logic              disp_ok,
  output logic              grant_pulse,
  output logic              deny_pulse
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [NCH-1:0]  r_sync_p0;
  logic [NCH-1:0]  r_sync_p1;
  logic [NCH-1:0]  r_db;
  logic [NCH-1:0]  r_db_d;
  logic [DBW-1:0]  r_db_cnt [NCH];
  logic [NCH-1:0]  r_pend;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_hold_last;

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_ch;
  logic [HCW-1:0]  r_hold_cnt;

  logic [SELW-1:0] w_win;
  logic [NCH-1:0]  w_press;
  logic [NCH-1:0]  w_clr;
  logic [CW-1:0]   w_sel_code;
  logic            w_sel_en;
  logic            w_ok;

  logic            r_busy;
  logic            r_disp_valid;
  logic [SELW-1:0] r_disp_ch;
  logic [CW-1:0]   r_disp_code;
  logic            r_disp_ok;
  logic            r_grant;
  logic            r_deny;

  // Stage p0/p1: two-flop synchroniser, then per-channel debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_db      <= '1;
      r_db_d    <= '1;
      for (int i = 0; i < NCH; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= btn_n;
      r_sync_p1 <= r_sync_p0;
      r_db_d    <= r_db;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync_p1[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync_p1[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the debounced 1->0 edge; releases are ignored
  assign w_press = r_db_d & ~r_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_press;
    end
  end

  // Round-robin search begins one past the last winner
  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    w_win = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = SELW'((int'(r_ptr) + k) % NCH);
      if (!found && r_pend[idx]) begin
        w_win = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[w_win] = 1'b1;
  end

  always_comb begin
    w_sel_code = '0;
    w_sel_en   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == SELW'(i)) begin
        w_sel_code = sw_code[i*CW +: CW];
        w_sel_en   = sw_en[i];
      end
    end
    w_ok = w_sel_en & (|w_sel_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hold_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_hold_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p2: latch winner, sample switches in EVAL, hold the display window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= SELW'(NCH - 1);
      r_ch         <= '0;
      r_hold_cnt   <= '0;
      r_busy       <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_ch    <= '0;
      r_disp_code  <= '0;
      r_disp_ok    <= 1'b0;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_ch  <= w_win;
        r_ptr <= w_win;
      end
      if (r_state == S_EVAL) begin
        r_disp_ch    <= r_ch;
        r_disp_code  <= w_sel_code;
        r_disp_ok    <= w_ok;
        r_disp_valid <= 1'b1;
        r_grant      <= w_ok;
        r_deny       <= ~w_ok;
        r_hold_cnt   <= '0;
      end else begin
        r_grant <= 1'b0;
        r_deny  <= 1'b0;
      end
      if (r_state == S_HOLD) begin
        if (w_hold_last) r_disp_valid <= 1'b0;
        else             r_hold_cnt   <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign pend_led    = r_pend;
  assign busy        = r_busy;
  assign disp_valid  = r_disp_valid;
  assign disp_ch     = r_disp_ch;
  assign disp_code   = r_disp_code;
  assign disp_ok     = r_disp_ok;
  assign grant_pulse = r_grant;
  assign deny_pulse  = r_deny;

endmodule
